gpr_file_mp: RTL and testbench
==============================

# gpr_file_mp

Parametrised multi-port general-purpose register file for the PPC core, successor to the fixed 3-read/2-write GPR. It provides NRD combinational read ports and NWR write ports with a consistent priority rule, same-cycle write-to-read bypass, a per-register busy scoreboard for issue-stage hazard checks, and a post-reset zeroing sweep so the storage array itself needs no reset. It sits between decode/issue (reads, reservations) and write-back (writes).

## Interface
- GPR_WIDTH, 32, data width of each register
- GPR_DEPTH, 5, address width; the file holds 2**GPR_DEPTH registers
- NRD, 3, number of read ports (1..8)
- NWR, 2, number of write ports (1..4)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- raddr  in  NRD*GPR_DEPTH  read addresses, port k at bits [k*GPR_DEPTH +: GPR_DEPTH]
- rd  out  NRD*GPR_WIDTH  read data, port k packed the same way
- rd_busy  out  NRD  register addressed by read port k is awaiting a write
- wr  in  NWR  write enables
- waddr  in  NWR*GPR_DEPTH  write addresses
- wd  in  NWR*GPR_WIDTH  write data
- rsv_en  in  1  mark register rsv_addr busy (instruction issued that will write it)
- rsv_addr  in  GPR_DEPTH  register to reserve
- ready  out  1  zeroing sweep finished; file accepts writes/reservations

## Operation
- FSM states: INIT, RUN. rst_n low forces INIT, sweep counter = 0, all busy bits = 0, ready = 0.
- INIT: each cycle writes 0 to entry[counter], counter increments; after entry 2**GPR_DEPTH-1 is written, next state RUN. Duration exactly 2**GPR_DEPTH cycles after reset release. Port writes and reservations are ignored in INIT; all rd outputs read 0, all rd_busy read 0.
- RUN: ready = 1; stays in RUN until rst_n asserts.
- Write: for each port j with wr[j]=1, entry[waddr[j]] <= wd[j] at clock edge. Collision (several enabled ports, same address): highest-index port wins. Different addresses: all commit.
- Read port k (RUN): if any enabled write port targets raddr[k], rd[k] = wd of the highest-index such port (bypass, same priority as storage); else rd[k] = entry[raddr[k]]. Bypass uses wr[j] qualification (unlike old GPR, disabled ports never forward).
- Busy: rsv_en sets busy[rsv_addr]; any enabled write to address a clears busy[a]. Same-cycle reservation and write to the same address: busy ends set (new producer wins).
- rd_busy[k] = busy[raddr[k]] and not (any enabled write this cycle to raddr[k]) — data is being bypassed, so no hazard. A reservation in the current cycle does not affect rd_busy until the next cycle.
- No register is hard-wired to zero; r0 behaves like any other entry.

## Timing
- Reset values: ready = 0, rd = 0, rd_busy = 0, busy array = 0, state INIT, counter 0. Assertion takes effect immediately (asynchronous), including mid-sweep or mid-RUN; a write on the assertion edge is lost.
- Read latency 0 (combinational from raddr, wr, waddr, wd). Write latency: visible via bypass same cycle, from storage next cycle.
- Reservation latency: busy visible on rd_busy one cycle after rsv_en.
- ready rises on the cycle after entry 2**GPR_DEPTH-1 is cleared (32 cycles after reset release for defaults).

## Test plan
- Reset release with defaults: ready low for 32 cycles, then high; reads of r0..r31 all return 0x00000000; writes issued in INIT (wr[0]=1, r5, 0xDEADBEEF) leave r5 = 0.
- Ports 0 and 1 both write r7 (0x11111111, 0x22222222): same-cycle rd of r7 = 0x22222222; next cycle still 0x22222222.
- wr[0]=0 with waddr[0]=r3, wd[0]=0xFFFFFFFF while r3 holds 0x12345678: rd of r3 = 0x12345678 (no false bypass).
- rsv_en r9 at cycle t: rd_busy for r9 = 0 at t, 1 at t+1; write r9 (0xA5A5A5A5) at t+3: rd_busy = 0 and rd = 0xA5A5A5A5 at t+3, busy cleared at t+4; rsv and write r9 same cycle: busy = 1 after.
- Assert rst_n mid-RUN with r4 = 0xCAFEF00D, r4 busy: ready, rd_busy drop immediately; after new sweep r4 reads 0.
- Parameter sweep NRD=4, NWR=3, GPR_WIDTH=64, GPR_DEPTH=6: 64-cycle init, port-2 priority over ports 0/1 on collisions, all four read ports bypass independently.

Source files
------------

// File: rtl/gpr_file_mp_if.sv
// Bundle of read, write and reservation signals between issue/write-back and the GPR file.
interface gpr_file_mp_if #(
  parameter int unsigned GPR_WIDTH = 32,
  parameter int unsigned GPR_DEPTH = 5,
  parameter int unsigned NRD       = 3,
  parameter int unsigned NWR       = 2
);
  logic [NRD*GPR_DEPTH-1:0] raddr;
  logic [NRD*GPR_WIDTH-1:0] rd;
  logic [NRD-1:0]           rd_busy;
  logic [NWR-1:0]           wr;
  logic [NWR*GPR_DEPTH-1:0] waddr;
  logic [NWR*GPR_WIDTH-1:0] wd;
  logic                     rsv_en;
  logic [GPR_DEPTH-1:0]     rsv_addr;
  logic                     ready;

  modport master (
    output raddr, wr, waddr, wd, rsv_en, rsv_addr,
    input  rd, rd_busy, ready
  );

  modport slave (
    input  raddr, wr, waddr, wd, rsv_en, rsv_addr,
    output rd, rd_busy, ready
  );
endinterface

// File: rtl/gpr_file_mp.sv
// Multi-port GPR file: zeroing sweep after reset, write-to-read bypass with
// highest-port priority, and a per-register busy scoreboard.
module gpr_file_mp #(
  parameter int unsigned GPR_WIDTH = 32,
  parameter int unsigned GPR_DEPTH = 5,
  parameter int unsigned NRD       = 3,
  parameter int unsigned NWR       = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  gpr_file_mp_if.slave  bus
);
  localparam int unsigned NREG = 2**GPR_DEPTH;

  typedef enum logic {INIT, RUN} state_t;

  state_t                 state_q, state_d;
  logic [GPR_DEPTH-1:0]   cnt_q, cnt_d;
  logic [NREG-1:0]        busy_q, busy_d;
  logic [GPR_WIDTH-1:0]   entry [NREG];
  logic [NRD*GPR_WIDTH-1:0] rd_c;
  logic [NRD-1:0]         rd_busy_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Sweep sequencing: one entry cleared per cycle, RUN after the last one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + GPR_DEPTH'(1);
        if (cnt_q == GPR_DEPTH'(NREG - 1)) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // Writes clear busy first so a same-cycle reservation leaves the register busy.
  always_comb begin
    busy_d = busy_q;
    if (state_q == RUN) begin
      for (int j = 0; j < int'(NWR); j++) begin
        if (bus.wr[j]) busy_d[bus.waddr[j*GPR_DEPTH +: GPR_DEPTH]] = 1'b0;
      end
      if (bus.rsv_en) busy_d[bus.rsv_addr] = 1'b1;
    end
  end

  // Storage has no reset; the sweep zeroes it. Later ports overwrite earlier ones.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      entry[cnt_q] <= '0;
    end else begin
      for (int j = 0; j < int'(NWR); j++) begin
        if (bus.wr[j]) entry[bus.waddr[j*GPR_DEPTH +: GPR_DEPTH]] <= bus.wd[j*GPR_WIDTH +: GPR_WIDTH];
      end
    end
  end

  // Read ports with bypass; a bypassed register is never reported busy.
  always_comb begin
    rd_c      = '0;
    rd_busy_c = '0;
    if (state_q == RUN) begin
      for (int k = 0; k < int'(NRD); k++) begin
        rd_c[k*GPR_WIDTH +: GPR_WIDTH] = entry[bus.raddr[k*GPR_DEPTH +: GPR_DEPTH]];
        rd_busy_c[k] = busy_q[bus.raddr[k*GPR_DEPTH +: GPR_DEPTH]];
        for (int j = 0; j < int'(NWR); j++) begin
          if (bus.wr[j] &&
              (bus.waddr[j*GPR_DEPTH +: GPR_DEPTH] == bus.raddr[k*GPR_DEPTH +: GPR_DEPTH])) begin
            rd_c[k*GPR_WIDTH +: GPR_WIDTH] = bus.wd[j*GPR_WIDTH +: GPR_WIDTH];
            rd_busy_c[k] = 1'b0;
          end
        end
      end
    end
  end

  assign bus.rd      = rd_c;
  assign bus.rd_busy = rd_busy_c;
  assign bus.ready   = (state_q == RUN);
endmodule

// File: tb/tb_gpr_file_mp.sv
// Randomised bench for gpr_file_mp: default and wide instances checked against
// an array-based register-file model.
module tb_gpr_file_mp;
  localparam int unsigned AW = 32, AD = 5, ANR = 3, ANW = 2;
  localparam int unsigned BW = 64, BD = 6, BNR = 4, BNW = 3;

  logic clk;
  logic rst_a, rst_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  gpr_file_mp_if #(.GPR_WIDTH(AW), .GPR_DEPTH(AD), .NRD(ANR), .NWR(ANW)) ia ();
  gpr_file_mp_if #(.GPR_WIDTH(BW), .GPR_DEPTH(BD), .NRD(BNR), .NWR(BNW)) ib ();

  gpr_file_mp #(.GPR_WIDTH(AW), .GPR_DEPTH(AD), .NRD(ANR), .NWR(ANW)) dut_a (
    .clk(clk), .rst_n(rst_a), .bus(ia.slave));
  gpr_file_mp #(.GPR_WIDTH(BW), .GPR_DEPTH(BD), .NRD(BNR), .NWR(BNW)) dut_b (
    .clk(clk), .rst_n(rst_b), .bus(ib.slave));

  int n_chk, n_pass;

  // Which instance is under test and its geometry
  int sel, nrd, nwr, nreg;
  logic [63:0] wmask;

  // Stimulus for the current cycle
  logic [5:0]  s_raddr [4];
  logic        s_wr    [3];
  logic [5:0]  s_waddr [3];
  logic [63:0] s_wd    [3];
  logic        s_rsv;
  logic [5:0]  s_rsva;

  // Reference model: register contents, busy flags, cycles since reset release
  logic [63:0] m_mem [64];
  logic [63:0] m_busy;
  int          m_cyc;
  bit          in_rst;

  // Sampled DUT outputs
  logic [63:0] o_rd   [4];
  logic        o_busy [4];
  logic        o_ready;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
  endtask

  function automatic bit written(input logic [5:0] a);
    for (int j = 0; j < nwr; j++) if (s_wr[j] && s_waddr[j] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] exp_rd(input int k);
    if (m_cyc < nreg) return '0;
    for (int j = nwr - 1; j >= 0; j--)
      if (s_wr[j] && s_waddr[j] == s_raddr[k]) return s_wd[j] & wmask;
    return m_mem[s_raddr[k]];
  endfunction

  function automatic logic exp_busy(input int k);
    if (m_cyc < nreg) return 1'b0;
    return m_busy[s_raddr[k]] && !written(s_raddr[k]);
  endfunction

  task automatic clear_stim();
    for (int k = 0; k < 4; k++) s_raddr[k] = '0;
    for (int j = 0; j < 3; j++) begin
      s_wr[j] = 1'b0; s_waddr[j] = '0; s_wd[j] = '0;
    end
    s_rsv = 1'b0; s_rsva = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_mem[i] = '0;
    m_busy = '0;
    m_cyc  = 0;
  endtask

  task automatic use_inst(input int s);
    sel = s;
    if (s == 0) begin nrd = ANR; nwr = ANW; nreg = 2**AD; wmask = 64'h0000_0000_FFFF_FFFF; end
    else        begin nrd = BNR; nwr = BNW; nreg = 2**BD; wmask = '1; end
  endtask

  task automatic drive();
    if (sel == 0) begin
      for (int k = 0; k < int'(ANR); k++) ia.raddr[k*AD +: AD] = s_raddr[k][AD-1:0];
      for (int j = 0; j < int'(ANW); j++) begin
        ia.wr[j] = s_wr[j];
        ia.waddr[j*AD +: AD] = s_waddr[j][AD-1:0];
        ia.wd[j*AW +: AW] = s_wd[j][AW-1:0];
      end
      ia.rsv_en = s_rsv; ia.rsv_addr = s_rsva[AD-1:0];
    end else begin
      for (int k = 0; k < int'(BNR); k++) ib.raddr[k*BD +: BD] = s_raddr[k][BD-1:0];
      for (int j = 0; j < int'(BNW); j++) begin
        ib.wr[j] = s_wr[j];
        ib.waddr[j*BD +: BD] = s_waddr[j][BD-1:0];
        ib.wd[j*BW +: BW] = s_wd[j][BW-1:0];
      end
      ib.rsv_en = s_rsv; ib.rsv_addr = s_rsva[BD-1:0];
    end
  endtask

  task automatic sample();
    for (int k = 0; k < 4; k++) begin o_rd[k] = '0; o_busy[k] = 1'b0; end
    if (sel == 0) begin
      o_ready = ia.ready;
      for (int k = 0; k < int'(ANR); k++) begin
        o_rd[k] = 64'(ia.rd[k*AW +: AW]); o_busy[k] = ia.rd_busy[k];
      end
    end else begin
      o_ready = ib.ready;
      for (int k = 0; k < int'(BNR); k++) begin
        o_rd[k] = 64'(ib.rd[k*BW +: BW]); o_busy[k] = ib.rd_busy[k];
      end
    end
  endtask

  // One cycle: drive after the falling edge, check mid-cycle, then advance the model.
  task automatic step();
    drive();
    #1;
    sample();
    check("ready", 64'(o_ready), 64'(m_cyc >= nreg));
    for (int k = 0; k < nrd; k++) begin
      check($sformatf("rd%0d[r%0d]", k, s_raddr[k]), o_rd[k], exp_rd(k));
      check($sformatf("rd_busy%0d[r%0d]", k, s_raddr[k]), 64'(o_busy[k]), 64'(exp_busy(k)));
    end
    @(posedge clk);
    if (!in_rst) begin
      if (m_cyc >= nreg) begin
        for (int j = 0; j < nwr; j++) begin
          if (s_wr[j]) begin
            m_mem[s_waddr[j]]  = s_wd[j] & wmask;
            m_busy[s_waddr[j]] = 1'b0;
          end
        end
        if (s_rsv) m_busy[s_rsva] = 1'b1;
      end
      m_cyc++;
    end
    @(negedge clk);
  endtask

  task automatic rand_steps(input int n);
    int lim;
    for (int i = 0; i < n; i++) begin
      lim = ($urandom_range(0, 3) == 0) ? nreg - 1 : 7;
      for (int k = 0; k < 4; k++) s_raddr[k] = 6'($urandom_range(0, lim));
      for (int j = 0; j < 3; j++) begin
        s_wr[j]    = (j < nwr) ? 1'($urandom_range(0, 1)) : 1'b0;
        s_waddr[j] = 6'($urandom_range(0, lim));
        s_wd[j]    = {$urandom, $urandom};
      end
      s_rsv  = ($urandom_range(0, 2) == 0);
      s_rsva = 6'($urandom_range(0, lim));
      step();
    end
    clear_stim();
  endtask

  task automatic set_rst(input logic v);
    if (sel == 0) rst_a = v; else rst_b = v;
  endtask

  // Reset with a stray write and reservation held through the whole sweep.
  task automatic reset_and_sweep();
    set_rst(1'b0); in_rst = 1'b1; model_reset();
    step(); step();
    set_rst(1'b1); in_rst = 1'b0;
    s_wr[0] = 1'b1; s_waddr[0] = 6'd5; s_wd[0] = 64'hDEAD_BEEF_DEAD_BEEF;
    s_rsv = 1'b1; s_rsva = 6'd5;
    for (int k = 0; k < 4; k++) s_raddr[k] = 6'd5;
    for (int i = 0; i < nreg; i++) step();
    clear_stim();
  endtask

  initial begin
    n_chk = 0; n_pass = 0; in_rst = 1'b1;
    rst_a = 1'b0; rst_b = 1'b0;
    clear_stim(); model_reset();
    use_inst(1); drive();
    use_inst(0); drive();
    @(negedge clk);

    // Default instance: sweep, then every register reads zero
    reset_and_sweep();
    check("ready_after_sweep", 64'(o_ready), 64'd0);
    step();
    check("ready_run", 64'(o_ready), 64'd1);
    for (int a = 0; a < 32; a += 3) begin
      for (int k = 0; k < 3; k++) s_raddr[k] = 6'((a + k) % 32);
      step();
    end
    s_raddr[0] = 6'd5; step();
    check("r5_init_write_lost", o_rd[0], 64'd0);

    // Two ports collide on r7
    s_wr[0] = 1'b1; s_waddr[0] = 6'd7; s_wd[0] = 64'h1111_1111;
    s_wr[1] = 1'b1; s_waddr[1] = 6'd7; s_wd[1] = 64'h2222_2222;
    s_raddr[0] = 6'd7; step();
    check("r7_collide_bypass", o_rd[0], 64'h2222_2222);
    clear_stim(); s_raddr[0] = 6'd7; step();
    check("r7_collide_stored", o_rd[0], 64'h2222_2222);

    // Disabled port must not forward
    s_wr[1] = 1'b1; s_waddr[1] = 6'd3; s_wd[1] = 64'h1234_5678; step();
    clear_stim();
    s_waddr[0] = 6'd3; s_wd[0] = 64'hFFFF_FFFF; s_raddr[0] = 6'd3; step();
    check("r3_no_false_bypass", o_rd[0], 64'h1234_5678);

    // Reservation lifecycle on r9
    clear_stim(); s_raddr[0] = 6'd9; s_rsv = 1'b1; s_rsva = 6'd9; step();
    check("r9_busy_t", 64'(o_busy[0]), 64'd0);
    s_rsv = 1'b0; step();
    check("r9_busy_t1", 64'(o_busy[0]), 64'd1);
    step();
    s_wr[1] = 1'b1; s_waddr[1] = 6'd9; s_wd[1] = 64'hA5A5_A5A5; step();
    check("r9_busy_t3", 64'(o_busy[0]), 64'd0);
    check("r9_rd_t3", o_rd[0], 64'hA5A5_A5A5);
    s_wr[1] = 1'b0; step();
    check("r9_busy_t4", 64'(o_busy[0]), 64'd0);
    s_rsv = 1'b1; s_rsva = 6'd9; s_wr[0] = 1'b1; s_waddr[0] = 6'd9; s_wd[0] = 64'h5A5A_5A5A; step();
    clear_stim(); s_raddr[0] = 6'd9; step();
    check("r9_rsv_wins", 64'(o_busy[0]), 64'd1);

    rand_steps(300);

    // Reset in the middle of RUN
    s_wr[0] = 1'b1; s_waddr[0] = 6'd4; s_wd[0] = 64'hCAFE_F00D; s_rsv = 1'b1; s_rsva = 6'd4; step();
    clear_stim(); s_raddr[0] = 6'd4; step();
    check("r4_busy_before_rst", 64'(o_busy[0]), 64'd1);
    set_rst(1'b0); in_rst = 1'b1; model_reset(); step();
    check("ready_drop_async", 64'(o_ready), 64'd0);
    check("busy_drop_async", 64'(o_busy[0]), 64'd0);
    set_rst(1'b1); in_rst = 1'b0;
    for (int i = 0; i < 32; i++) step();
    step();
    check("r4_zero_after_resweep", o_rd[0], 64'd0);
    check("r4_not_busy_after_resweep", 64'(o_busy[0]), 64'd0);

    // Wide instance: 64-entry sweep, three-port priority, four independent bypasses
    use_inst(1); clear_stim(); model_reset();
    reset_and_sweep();
    check("b_ready_after_64", 64'(o_ready), 64'd0);
    for (int j = 0; j < 3; j++) begin
      s_wr[j] = 1'b1; s_waddr[j] = 6'd10; s_wd[j] = 64'h1000_0000_0000_0000 * (j + 1);
    end
    s_raddr[0] = 6'd10; step();
    check("b_r10_port2_wins", o_rd[0], 64'h3000_0000_0000_0000);
    clear_stim();
    s_wr[0] = 1'b1; s_waddr[0] = 6'd11; s_wd[0] = 64'h0123_4567_89AB_CDEF;
    s_waddr[1] = 6'd11; s_wd[1] = 64'hFFFF_0000_FFFF_0000;
    s_wr[2] = 1'b1; s_waddr[2] = 6'd11; s_wd[2] = 64'hFEDC_BA98_7654_3210;
    s_raddr[0] = 6'd11; s_raddr[1] = 6'd10; step();
    check("b_r11_port2_over_0", o_rd[0], 64'hFEDC_BA98_7654_3210);
    clear_stim(); s_wr[1] = 1'b1; s_waddr[1] = 6'd63; s_wd[1] = 64'h6363_6363_6363_6363; step();
    clear_stim();
    for (int j = 0; j < 3; j++) begin
      s_wr[j] = 1'b1; s_waddr[j] = 6'(20 + j); s_wd[j] = 64'hAB00_0000_0000_0000 + 64'(j);
    end
    for (int k = 0; k < 3; k++) s_raddr[k] = 6'(20 + k);
    s_raddr[3] = 6'd63; step();
    check("b_byp0", o_rd[0], 64'hAB00_0000_0000_0000);
    check("b_byp1", o_rd[1], 64'hAB00_0000_0000_0001);
    check("b_byp2", o_rd[2], 64'hAB00_0000_0000_0002);
    check("b_r63_stored", o_rd[3], 64'h6363_6363_6363_6363);
    clear_stim();
    rand_steps(300);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
